// File: rtl/pgm_rd.sv
// pgm_rd: forwards bypass words from pgm_wr while idle, or replays the packet held
// in PGM_RAM a configured number of times with an idle gap between copies.
module pgm_rd (
    input  logic          clk,
    input  logic          rst,
    input  logic [133:0]  in_rd_data,
    input  logic          in_rd_data_wr,
    input  logic [1023:0] in_rd_phv,
    input  logic          in_rd_phv_wr,
    input  logic          in_rd_valid,
    input  logic          in_rd_valid_wr,
    input  logic          pgm_bypass_flag,
    input  logic          pgm_sent_start_flag,
    input  logic          pgm_sent_finish_flag,
    output logic          rd2ram_rd_en,
    output logic [6:0]    rd2ram_addr,
    input  logic [143:0]  ram2rd_rdata,
    input  logic [31:0]   cfg_pkt_num,
    input  logic [15:0]   cfg_gap,
    input  logic          in_rd_alf,
    output logic [133:0]  out_rd_data,
    output logic          out_rd_data_wr,
    output logic [1023:0] out_rd_phv,
    output logic          out_rd_phv_wr,
    output logic          out_rd_valid,
    output logic          out_rd_valid_wr,
    output logic [31:0]   sent_pkt_cnt,
    output logic [31:0]   bypass_drop_cnt
);
    typedef enum logic [1:0] {IDLE, RD_WORD, GAP, DONE} state_t;

    state_t state_q, state_d;
    logic [6:0] addr_q, addr_d, pend_addr_q, pend_addr_d, rd_addr;
    logic pend_q, pend_d, start_prev_q, start_prev_d, finish_prev_q, finish_prev_d, fin_q, fin_d;
    logic [31:0] copy_q, copy_d, sent_q, sent_d, drop_q, drop_d;
    logic [15:0] gap_q, gap_d;
    logic [133:0] data_q, data_d;
    logic [1023:0] phv_q, phv_d;
    logic data_wr_q, data_wr_d, phv_wr_q, phv_wr_d, valid_q, valid_d, valid_wr_q, valid_wr_d;
    logic start_edge, fin_edge, tail_now, last, launch, rd_en;
    logic [1:0] hdr, hdr_out;
    logic unused;

    assign unused = ^{pgm_bypass_flag, ram2rd_rdata[143:134]};

    always_comb begin
        start_edge = pgm_sent_start_flag & ~start_prev_q;
        fin_edge = pgm_sent_finish_flag & ~finish_prev_q;
        hdr = ram2rd_rdata[133:132];
        // a word read from the last address closes the packet even without a tail header
        tail_now = pend_q & (hdr == 2'b10 | pend_addr_q == 7'd127);
        hdr_out = tail_now ? 2'b10 : hdr;
        last = (cfg_pkt_num != 32'd0 && copy_q + 32'd1 == cfg_pkt_num) || fin_q || fin_edge;
        // launch restarts a copy at address 0 in the same cycle, so gap=0 leaves no bubble
        launch = (state_q == RD_WORD && tail_now && !last && cfg_gap == 16'd0) ||
                 (state_q == GAP && gap_q < 16'd2);
        rd_en = !in_rd_alf && ((state_q == RD_WORD && !tail_now) || launch);
        rd_addr = launch ? 7'd0 : addr_q;
        state_d = state_q;
        addr_d = rd_en ? rd_addr + 7'd1 : rd_addr;
        pend_d = rd_en;
        pend_addr_d = rd_addr;
        start_prev_d = pgm_sent_start_flag;
        finish_prev_d = pgm_sent_finish_flag;
        fin_d = fin_q | (fin_edge & (state_q == RD_WORD | state_q == GAP));
        copy_d = copy_q + {31'd0, tail_now};
        sent_d = sent_q + {31'd0, tail_now};
        drop_d = drop_q + {31'd0, in_rd_data_wr & (state_q != IDLE | start_edge)};
        gap_d = gap_q;
        if (state_q == IDLE && start_edge) begin
            state_d = RD_WORD;
            addr_d = 7'd0;
            copy_d = 32'd0;
            fin_d = 1'b0;
        end else if (state_q == RD_WORD && tail_now) begin
            state_d = last ? DONE : (launch ? RD_WORD : GAP);
            gap_d = cfg_gap;
            addr_d = launch ? addr_d : 7'd0;
        end else if (state_q == GAP) begin
            state_d = launch ? RD_WORD : GAP;
            gap_d = gap_q - 16'd1;
        end else if (state_q == DONE) begin
            state_d = IDLE;
            fin_d = 1'b0;
        end
        data_d = '0;
        phv_d = '0;
        data_wr_d = 1'b0;
        phv_wr_d = 1'b0;
        valid_d = 1'b0;
        valid_wr_d = 1'b0;
        if (pend_q) begin
            data_d = {hdr_out, ram2rd_rdata[131:0]};
            data_wr_d = 1'b1;
            phv_wr_d = hdr_out == 2'b01;
            valid_d = tail_now;
            valid_wr_d = tail_now;
        end else if (state_q == IDLE && !start_edge) begin
            data_d = in_rd_data;
            data_wr_d = in_rd_data_wr;
            phv_d = in_rd_phv;
            phv_wr_d = in_rd_phv_wr;
            valid_d = in_rd_valid;
            valid_wr_d = in_rd_valid_wr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q <= '0;
            pend_addr_q <= '0;
            pend_q <= 1'b0;
            start_prev_q <= 1'b0;
            finish_prev_q <= 1'b0;
            fin_q <= 1'b0;
            copy_q <= '0;
            sent_q <= '0;
            drop_q <= '0;
            gap_q <= '0;
            data_q <= '0;
            phv_q <= '0;
            data_wr_q <= 1'b0;
            phv_wr_q <= 1'b0;
            valid_q <= 1'b0;
            valid_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            pend_addr_q <= pend_addr_d;
            pend_q <= pend_d;
            start_prev_q <= start_prev_d;
            finish_prev_q <= finish_prev_d;
            fin_q <= fin_d;
            copy_q <= copy_d;
            sent_q <= sent_d;
            drop_q <= drop_d;
            gap_q <= gap_d;
            data_q <= data_d;
            phv_q <= phv_d;
            data_wr_q <= data_wr_d;
            phv_wr_q <= phv_wr_d;
            valid_q <= valid_d;
            valid_wr_q <= valid_wr_d;
        end
    end

    assign rd2ram_rd_en = rd_en;
    assign rd2ram_addr = rd_addr;
    assign out_rd_data = data_q;
    assign out_rd_data_wr = data_wr_q;
    assign out_rd_phv = phv_q;
    assign out_rd_phv_wr = phv_wr_q;
    assign out_rd_valid = valid_q;
    assign out_rd_valid_wr = valid_wr_q;
    assign sent_pkt_cnt = sent_q;
    assign bypass_drop_cnt = drop_q;
endmodule

// File: tb/tb_pgm_rd.sv
// tb_pgm_rd: directed scenarios for pgm_rd against a 1-cycle-latency RAM model.
module tb_pgm_rd;
    logic clk = 1'b0, rst = 1'b1;
    logic [133:0] in_rd_data = '0;
    logic in_rd_data_wr = 1'b0, in_rd_phv_wr = 1'b0, in_rd_valid = 1'b0, in_rd_valid_wr = 1'b0;
    logic [1023:0] in_rd_phv = '0;
    logic pgm_bypass_flag = 1'b0, pgm_sent_start_flag = 1'b0, pgm_sent_finish_flag = 1'b0;
    logic rd2ram_rd_en;
    logic [6:0] rd2ram_addr;
    logic [143:0] ram2rd_rdata;
    logic [31:0] cfg_pkt_num = '0;
    logic [15:0] cfg_gap = '0;
    logic in_rd_alf = 1'b0;
    logic [133:0] out_rd_data;
    logic out_rd_data_wr, out_rd_phv_wr, out_rd_valid, out_rd_valid_wr;
    logic [1023:0] out_rd_phv;
    logic [31:0] sent_pkt_cnt, bypass_drop_cnt;
    logic [143:0] mem [0:127];
    logic [143:0] ram_q = '0;
    logic [1023:0] phv_pat = {32{32'hDEADBEEF}};
    int checks = 0, errors = 0;
    logic [133:0] cap_d [$];
    int cap_t [$];
    logic cap_h [$], cap_v [$], cap_p [$];

    pgm_rd dut (
        .clk(clk), .rst(rst),
        .in_rd_data(in_rd_data), .in_rd_data_wr(in_rd_data_wr),
        .in_rd_phv(in_rd_phv), .in_rd_phv_wr(in_rd_phv_wr),
        .in_rd_valid(in_rd_valid), .in_rd_valid_wr(in_rd_valid_wr),
        .pgm_bypass_flag(pgm_bypass_flag), .pgm_sent_start_flag(pgm_sent_start_flag),
        .pgm_sent_finish_flag(pgm_sent_finish_flag),
        .rd2ram_rd_en(rd2ram_rd_en), .rd2ram_addr(rd2ram_addr), .ram2rd_rdata(ram2rd_rdata),
        .cfg_pkt_num(cfg_pkt_num), .cfg_gap(cfg_gap), .in_rd_alf(in_rd_alf),
        .out_rd_data(out_rd_data), .out_rd_data_wr(out_rd_data_wr),
        .out_rd_phv(out_rd_phv), .out_rd_phv_wr(out_rd_phv_wr),
        .out_rd_valid(out_rd_valid), .out_rd_valid_wr(out_rd_valid_wr),
        .sent_pkt_cnt(sent_pkt_cnt), .bypass_drop_cnt(bypass_drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (rd2ram_rd_en) ram_q <= mem[rd2ram_addr];
    assign ram2rd_rdata = ram_q;

    function automatic logic [143:0] mk(input logic [1:0] h, input int a);
        return {10'h2A5, h, 100'h5, a[31:0] ^ 32'hC0DE0000};
    endfunction

    function automatic logic [133:0] wd(input int a);
        logic [143:0] t;
        t = mem[a];
        return t[133:0];
    endfunction

    task automatic load(input int tail_at);
        for (int a = 0; a < 128; a++) mem[a] = mk(2'b11, a);
        mem[0] = mk(2'b01, 0);
        if (tail_at >= 0) mem[tail_at] = mk(2'b10, tail_at);
    endtask

    task automatic grab(input int cyc);
        if (out_rd_data_wr) begin
            cap_d.push_back(out_rd_data);
            cap_t.push_back(cyc);
            cap_h.push_back(out_rd_phv_wr);
            cap_v.push_back(out_rd_valid_wr);
            cap_p.push_back(|out_rd_phv);
        end
    endtask

    task automatic start_gen(input logic [31:0] n, input logic [15:0] g);
        cfg_pkt_num = n;
        cfg_gap = g;
        cap_d.delete(); cap_t.delete(); cap_h.delete(); cap_v.delete(); cap_p.delete();
        @(negedge clk) pgm_sent_start_flag = 1'b0;
        @(negedge clk) pgm_sent_start_flag = 1'b1;
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            grab(c);
        end
    endtask

    task automatic test_reset();
        in_rd_data_wr = 1'b1;
        in_rd_data = 134'h1234;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_rd_data_wr, out_rd_phv_wr, out_rd_valid_wr, rd2ram_rd_en, out_rd_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got wr=%b data=%h want all zero", out_rd_data_wr, out_rd_data);
        end
        checks++;
        if ({sent_pkt_cnt, bypass_drop_cnt} !== 64'd0) begin
            errors++;
            $display("FAIL reset_counters: got sent=%0d drop=%0d want 0 0", sent_pkt_cnt, bypass_drop_cnt);
        end
        in_rd_data_wr = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_bypass();
        logic [133:0] w [3];
        logic [1:0] hs [3];
        logic [143:0] t;
        hs[0] = 2'b01; hs[1] = 2'b11; hs[2] = 2'b10;
        for (int i = 0; i < 3; i++) begin
            t = mk(hs[i], 100 + i);
            w[i] = t[133:0];
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if ({out_rd_data_wr, out_rd_phv_wr, out_rd_valid_wr, out_rd_valid, out_rd_data} !==
                    {1'b1, i == 1, i == 3, i == 3, w[i-1]}) begin
                    errors++;
                    $display("FAIL bypass_word%0d: got %b%b%b %h want %b%b%b %h", i - 1, out_rd_data_wr,
                             out_rd_phv_wr, out_rd_valid_wr, out_rd_data, 1'b1, i == 1, i == 3, w[i-1]);
                end
                checks++;
                if (out_rd_phv !== phv_pat) begin
                    errors++;
                    $display("FAIL bypass_phv%0d: phv not forwarded unchanged", i - 1);
                end
            end
            in_rd_data_wr = i < 3;
            in_rd_data = i < 3 ? w[i] : '0;
            in_rd_phv = phv_pat;
            in_rd_phv_wr = i == 0;
            in_rd_valid = i == 2;
            in_rd_valid_wr = i == 2;
        end
        @(negedge clk);
        checks++;
        if (out_rd_data_wr !== 1'b0 || bypass_drop_cnt !== 32'd0) begin
            errors++;
            $display("FAIL bypass_idle: got wr=%b drop=%0d want 0 0", out_rd_data_wr, bypass_drop_cnt);
        end
        in_rd_phv = '0;
    endtask

    task automatic test_gen();
        load(3);
        start_gen(3, 2);
        run(60);
        pgm_sent_start_flag = 1'b0;
        checks++;
        if (cap_d.size() != 12) begin
            errors++;
            $display("FAIL gen_count: got %0d words want 12", cap_d.size());
        end
        for (int k = 0; k < cap_d.size() && k < 12; k++) begin
            checks++;
            if ({cap_d[k], cap_h[k], cap_v[k], cap_p[k]} !== {wd(k % 4), k % 4 == 0, k % 4 == 3, 1'b0}) begin
                errors++;
                $display("FAIL gen_word%0d: got %h h%b v%b p%b want %h h%b v%b p0", k, cap_d[k], cap_h[k],
                         cap_v[k], cap_p[k], wd(k % 4), k % 4 == 0, k % 4 == 3);
            end
            checks++;
            if ((k == 0 ? cap_t[0] : cap_t[k] - cap_t[k-1]) != (k == 0 ? 2 : (k % 4 == 0 ? 3 : 1))) begin
                errors++;
                $display("FAIL gen_time%0d: got cycle %0d want spacing %0d", k, cap_t[k],
                         k == 0 ? 2 : (k % 4 == 0 ? 3 : 1));
            end
        end
        checks++;
        if (sent_pkt_cnt !== 32'd3) begin
            errors++;
            $display("FAIL gen_sent: got %0d want 3", sent_pkt_cnt);
        end
        in_rd_data_wr = 1'b1;
        in_rd_data = 134'h77;
        @(negedge clk);
        in_rd_data_wr = 1'b0;
        checks++;
        if ({out_rd_data_wr, out_rd_data, bypass_drop_cnt} !== {1'b1, 134'h77, 32'd0}) begin
            errors++;
            $display("FAIL gen_back_idle: got wr=%b data=%h drop=%0d want 1 77 0", out_rd_data_wr,
                     out_rd_data, bypass_drop_cnt);
        end
    endtask

    task automatic test_finish();
        load(3);
        start_gen(0, 1);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            grab(c);
            if (cap_d.size() == 6) pgm_sent_finish_flag = 1'b1;
        end
        pgm_sent_start_flag = 1'b0;
        pgm_sent_finish_flag = 1'b0;
        checks++;
        if (cap_d.size() != 8 || sent_pkt_cnt !== 32'd5) begin
            errors++;
            $display("FAIL finish_count: got %0d words sent=%0d want 8 5", cap_d.size(), sent_pkt_cnt);
        end
        for (int k = 0; k < cap_d.size() && k < 8; k++) begin
            checks++;
            if ({cap_d[k], cap_v[k]} !== {wd(k % 4), k % 4 == 3}) begin
                errors++;
                $display("FAIL finish_word%0d: got %h v%b want %h v%b", k, cap_d[k], cap_v[k], wd(k % 4),
                         k % 4 == 3);
            end
        end
    endtask

    task automatic test_alf();
        int held = -1, after = 0;
        load(7);
        start_gen(1, 0);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            grab(c);
            if (held >= 0 && held < 5) begin
                if (out_rd_data_wr) after++;
                held++;
                if (held == 5) in_rd_alf = 1'b0;
            end else if (held < 0 && cap_d.size() == 2) begin
                in_rd_alf = 1'b1;
                held = 0;
            end
        end
        pgm_sent_start_flag = 1'b0;
        in_rd_alf = 1'b0;
        checks++;
        if (held != 5 || after > 1) begin
            errors++;
            $display("FAIL alf_stall: got %0d words while stalled (held %0d) want at most 1", after, held);
        end
        checks++;
        if (cap_d.size() != 8 || sent_pkt_cnt !== 32'd6) begin
            errors++;
            $display("FAIL alf_count: got %0d words sent=%0d want 8 6", cap_d.size(), sent_pkt_cnt);
        end
        for (int k = 0; k < cap_d.size() && k < 8; k++) begin
            checks++;
            if (cap_d[k] !== wd(k)) begin
                errors++;
                $display("FAIL alf_word%0d: got %h want %h", k, cap_d[k], wd(k));
            end
        end
    endtask

    task automatic test_wrap();
        logic [133:0] exp;
        load(-1);
        start_gen(1, 0);
        run(160);
        pgm_sent_start_flag = 1'b0;
        checks++;
        if (cap_d.size() != 128 || sent_pkt_cnt !== 32'd7) begin
            errors++;
            $display("FAIL wrap_count: got %0d words sent=%0d want 128 7", cap_d.size(), sent_pkt_cnt);
        end
        for (int k = 0; k < cap_d.size() && k < 128; k++) begin
            exp = wd(k);
            if (k == 127) exp[133:132] = 2'b10;
            checks++;
            if ({cap_d[k], cap_v[k]} !== {exp, k == 127}) begin
                errors++;
                $display("FAIL wrap_word%0d: got %h v%b want %h v%b", k, cap_d[k], cap_v[k], exp, k == 127);
            end
        end
    endtask

    task automatic test_collision();
        load(3);
        cfg_pkt_num = 1;
        cfg_gap = 0;
        cap_d.delete(); cap_t.delete(); cap_h.delete(); cap_v.delete(); cap_p.delete();
        @(negedge clk) pgm_sent_start_flag = 1'b0;
        @(negedge clk);
        pgm_sent_start_flag = 1'b1;
        in_rd_data_wr = 1'b1;
        in_rd_data = 134'h55;
        @(negedge clk);
        in_rd_data_wr = 1'b0;
        checks++;
        if (out_rd_data_wr !== 1'b0 || bypass_drop_cnt !== 32'd1) begin
            errors++;
            $display("FAIL collision_drop: got wr=%b drop=%0d want 0 1", out_rd_data_wr, bypass_drop_cnt);
        end
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            grab(c);
            if (c == 0) pgm_sent_start_flag = 1'b0;
            if (c == 1) pgm_sent_start_flag = 1'b1;
        end
        pgm_sent_start_flag = 1'b0;
        checks++;
        if (cap_d.size() != 4 || sent_pkt_cnt !== 32'd8) begin
            errors++;
            $display("FAIL collision_count: got %0d words sent=%0d want 4 8", cap_d.size(), sent_pkt_cnt);
        end
    endtask

    task automatic test_gap_drop_reset();
        int d = -1, strobes = 0;
        bit hit = 0;
        load(3);
        start_gen(2, 5);
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            grab(c);
            if (d < 0 && cap_d.size() == 4) begin
                in_rd_data_wr = 1'b1;
                in_rd_data = 134'h99;
                d = c;
            end else if (d >= 0 && c == d + 1) begin
                in_rd_data_wr = 1'b0;
                checks++;
                if (out_rd_data_wr !== 1'b0 || bypass_drop_cnt !== 32'd2) begin
                    errors++;
                    $display("FAIL gap_drop: got wr=%b drop=%0d want 0 2", out_rd_data_wr, bypass_drop_cnt);
                end
            end else if (cap_d.size() == 6) begin
                hit = 1;
                pgm_sent_start_flag = 1'b0;
                #1 rst = 1'b1;
                #1;
                checks++;
                if ({out_rd_data_wr, out_rd_phv_wr, out_rd_valid_wr, rd2ram_rd_en, out_rd_data,
                     sent_pkt_cnt, bypass_drop_cnt} !== '0) begin
                    errors++;
                    $display("FAIL reset_midpkt: got wr=%b data=%h sent=%0d want all zero", out_rd_data_wr,
                             out_rd_data, sent_pkt_cnt);
                end
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reset_reach: got %0d words before timeout want 6", cap_d.size());
        end
        rst = 1'b1;
        pgm_sent_start_flag = 1'b0;
        in_rd_data_wr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_rd_data_wr | out_rd_phv_wr | out_rd_valid_wr | rd2ram_rd_en) strobes++;
        end
        checks++;
        if (strobes != 0) begin
            errors++;
            $display("FAIL reset_quiet: got %0d strobe cycles want 0", strobes);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_gen();
        test_finish();
        test_alf();
        test_wrap();
        test_collision();
        test_gap_drop_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
